// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants for the interrupt arbiter
package irq_pkg;

    localparam int          N_SRC_DEF       = 3;
    localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0800;
    localparam int          VEC_SHIFT_DEF   = 4;
    localparam int          IDW_DEF         = $clog2(N_SRC_DEF);

endpackage

// File: rtl/irq_prio_encoder.sv
// rtl/irq_prio_encoder.sv - highest-set-bit encoder with valid flag
module irq_prio_encoder #(
    parameter int N   = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   vec,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - prioritising, nesting-aware interrupt arbiter
module interrupt_arbiter
    import irq_pkg::*;
#(
    parameter int          N_SRC       = N_SRC_DEF,
    parameter logic [31:0] VECTOR_BASE = VECTOR_BASE_DEF,
    parameter int          VEC_SHIFT   = VEC_SHIFT_DEF,
    localparam int         IDW         = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_req,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ie_we,
    input  logic             ie_wdata,
    input  logic             take,
    input  logic             eret,
    output logic             irq,
    output logic [IDW-1:0]   irq_id,
    output logic [31:0]      irq_vector,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service,
    output logic [N_SRC-1:0] mask,
    output logic             ie,
    output logic [31:0]      taken_count
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] above;
    logic [N_SRC-1:0] eligible;
    logic             is_valid;
    logic [IDW-1:0]   hi_is;
    logic             el_valid;
    logic [IDW-1:0]   el_idx;
    logic             take_ok;

    logic [N_SRC-1:0] pending_n;
    logic [N_SRC-1:0] in_service_n;
    logic [N_SRC-1:0] mask_n;
    logic             ie_n;
    logic [31:0]      count_n;

    irq_prio_encoder #(.N(N_SRC), .IDW(IDW)) u_is_enc (
        .vec   (in_service),
        .valid (is_valid),
        .idx   (hi_is)
    );

    irq_prio_encoder #(.N(N_SRC), .IDW(IDW)) u_el_enc (
        .vec   (eligible),
        .valid (el_valid),
        .idx   (el_idx)
    );

    // Only sources strictly above the innermost running handler may preempt.
    always_comb begin
        above = '0;
        for (int i = 0; i < N_SRC; i++) begin
            above[i] = !is_valid || (IDW'(i) > hi_is);
        end
    end

    assign edges      = src_req & ~src_q;
    assign eligible   = pending & mask & above;
    assign irq        = ie & el_valid;
    assign irq_id     = irq ? el_idx : '0;
    assign irq_vector = VECTOR_BASE + (32'(irq_id) << VEC_SHIFT);
    assign take_ok    = take & irq;

    // Ordering matters: eret retires before take, take overrides ie writes,
    // and a fresh edge survives a take of the same source.
    always_comb begin
        pending_n    = pending;
        in_service_n = in_service;
        mask_n       = mask;
        ie_n         = ie;
        count_n      = taken_count;
        if (mask_we) begin
            mask_n = mask_wdata;
        end
        if (eret) begin
            if (is_valid) begin
                in_service_n[hi_is] = 1'b0;
            end
            ie_n = 1'b1;
        end
        if (ie_we) begin
            ie_n = ie_wdata;
        end
        if (take_ok) begin
            pending_n[irq_id]    = 1'b0;
            in_service_n[irq_id] = 1'b1;
            ie_n                 = 1'b0;
            count_n              = taken_count + 32'd1;
        end
        pending_n = pending_n | edges;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '1;
            pending     <= '0;
            in_service  <= '0;
            mask        <= '1;
            ie          <= 1'b0;
            taken_count <= '0;
        end else begin
            src_q       <= src_req;
            pending     <= pending_n;
            in_service  <= in_service_n;
            mask        <= mask_n;
            ie          <= ie_n;
            taken_count <= count_n;
        end
    end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Prioritising, nesting-aware interrupt arbiter between the external exception sources (`ExpSrc` lines) and the CPU/CP0 exception-entry path. It latches request edges into pending bits, applies per-source masks and a global enable, and presents one winning request plus its handler vector to the core. The core accepts that request at an instruction boundary. In-service state is tracked so that only strictly higher-priority sources preempt a running handler, and `eret` retires the innermost handler.

## Interface
Parameters:
- `N_SRC`, 3: number of interrupt sources.
- `VECTOR_BASE`, 32'h0000_0800: handler vector for source 0.
- `VEC_SHIFT`, 4: vector stride is `1 << VEC_SHIFT` bytes per source id.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `src_req`, in, N_SRC: level requests, synchronous to `clk`; a 0→1 transition is one request.
- `mask_we`, in, 1: write strobe for `mask`.
- `mask_wdata`, in, N_SRC: new mask value; bit = 1 means the source is enabled.
- `ie_we`, in, 1: write strobe for the global enable.
- `ie_wdata`, in, 1: new global enable value.
- `take`, in, 1: one-cycle pulse; core enters the handler for `irq_id`. Ignored when `irq`=0.
- `eret`, in, 1: one-cycle pulse; core returns from the innermost handler.
- `irq`, out, 1: request to core.
- `irq_id`, out, $clog2(N_SRC): winning source id; valid while `irq`=1, 0 otherwise.
- `irq_vector`, out, 32: `VECTOR_BASE + (irq_id << VEC_SHIFT)`.
- `pending`, out, N_SRC: latched, not-yet-taken requests.
- `in_service`, out, N_SRC: handlers entered and not yet retired.
- `mask`, out, N_SRC: current mask.
- `ie`, out, 1: current global enable.
- `taken_count`, out, 32: number of accepted `take`s; wraps modulo 2^32.

## Operation
- Priority: a higher index means higher priority; source N_SRC-1 is highest.
- Edge detect: a registered copy `src_q` tracks `src_req`. An edge (`src_req & ~src_q`) sets the corresponding `pending` bit.
  - A new edge on a source that is already pending is absorbed.
  - An edge on an in-service source sets `pending` again; that source re-fires only after it is retired.
- `hi_is` = index of the highest set `in_service` bit, or "none".
- `eligible = pending & mask`, restricted to indices strictly above `hi_is`.
- `irq = ie & |eligible`. `irq_id` = highest set bit of `eligible`.
- On `take` with `irq`=1:
  - clear `pending[irq_id]` and set `in_service[irq_id]`;
  - set `ie` to 0 (the handler re-enables it via `ie_we`);
  - increment `taken_count`.
- On `eret`: clear `in_service[hi_is]` (no change if "none") and set `ie` to 1.
- States are derived from the registers, not separately encoded:
  - IDLE: `in_service`=0, `irq`=0.
  - REQ: `in_service`=0, `irq`=1.
  - SERVICE: `in_service`≠0, `irq`=0.
  - PREEMPT: `in_service`≠0, `irq`=1.
  - `take` moves REQ→SERVICE and PREEMPT→SERVICE at the next nesting level. `eret` retires one level, toward IDLE or REQ.

## Timing
- Reset values: `pending`=0, `in_service`=0, `mask`=all ones, `ie`=0, `taken_count`=0, `src_q`=all ones. Consequently `irq`=0, `irq_id`=0, `irq_vector`=`VECTOR_BASE`.
  - Because `src_q` resets to all ones, lines held high through reset do not fire.
- Latency: edge sampled at clock edge k sets `pending` at edge k; `irq` is high in cycle k+1 (combinational from registers, no extra stage).
- `take` is evaluated against the `irq`/`irq_id` presented in that cycle. Mask and `ie` writes made in the same cycle do not affect that take.
- Simultaneous events:
  - `eret` + `take`: retirement applies first, then the take is applied; `ie` ends at 0.
  - `ie_we` + `take`: `ie` ends at 0.
  - `ie_we` + `eret`: `ie_wdata` wins.
  - `mask_we`: takes effect on `irq` from the next cycle.
  - Edge on a source + `take` of the same source: pending ends at 1 (new request kept).
- `rst` mid-handler discards all nesting, pending and counts at that edge.
- `taken_count` at 32'hFFFF_FFFF plus `take` → 0.

## Structure
- Shared package `irq_pkg`: `N_SRC` default, `VECTOR_BASE`, `VEC_SHIFT`, `IDW = $clog2(N_SRC)`.
- One sub-module, `irq_prio_encoder` (N-bit vector → {valid, highest-set index}), instantiated twice: once for `eligible` and once for `in_service`.

## Test plan
- Reset with `src_req`=3'b111 held → no `pending` bits set; `irq`=0 for 10 cycles; drop then raise bit 1 with `ie`=1 → `pending`=3'b010, `irq_id`=1, `irq_vector`=32'h810 in the next cycle.
- Edges on bits 0 and 2 in the same cycle, `ie`=1 → `irq_id`=2; `take` → `in_service`=3'b100, `ie`=0, `irq`=0, `taken_count`=1.
- Nesting: source 0 in service with `ie`=1, edge on source 2 → `irq`=1, `irq_id`=2; `take`, then `eret` → `in_service`=3'b001, `ie`=1. An edge on source 0 while it is in service yields no `irq` until the second `eret`.
- `mask_wdata`=3'b011, edge on source 2 → `pending`=3'b100, `irq`=0; unmask → `irq`=1 in the next cycle.
- `take` + `eret` in the same cycle with `in_service`=3'b001 and source 2 pending → `in_service`=3'b100, `ie`=0. `eret` with `in_service`=0 → only `ie`=1.
- Preload `taken_count` to 32'hFFFF_FFFF via 2^32 − 1 takes (or a force), then one `take` → `taken_count`=0. Assert `rst` mid-handler → every output returns to its reset value.
